// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and recovers the hex
// nibble shown on each digit, with frame and malformed-pattern reporting.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic [6:0]              seg_in,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_valid,
  output logic                    pattern_err,
  output logic [3:0]              err_digit
);

  typedef enum logic [1:0] {
    S_WAIT,
    S_SETTLE,
    S_HOLD
  } state_t;

  state_t                          r_state;
  logic [NUM_DIGITS-1:0]           r_an_q;
  logic [6:0]                      r_seg_q;
  logic [NUM_DIGITS-1:0]           r_snap_an;
  logic [6:0]                      r_snap_seg;
  logic [CNT_W-1:0]                r_cnt;
  logic                            r_cap;
  logic [NUM_DIGITS-1:0]           r_cap_sel;
  logic [3:0]                      r_cap_idx;
  logic [6:0]                      r_cap_seg;
  logic [NUM_DIGITS-1:0][3:0]      r_digits;
  logic [NUM_DIGITS-1:0]           r_valid;
  logic [NUM_DIGITS-1:0]           r_set;
  logic                            r_frame;
  logic                            r_err;
  logic [3:0]                      r_err_idx;

  logic [NUM_DIGITS-1:0] w_low;
  logic                  w_legal;
  logic                  w_match;
  logic [3:0]            w_idx;
  logic [4:0]            w_dec;
  logic [NUM_DIGITS-1:0] w_set_nxt;

  // {is_hex, nibble}
  function automatic logic [4:0] f_decode(input logic [6:0] s);
    case (s)
      7'h40:   return {1'b1, 4'h0};
      7'h79:   return {1'b1, 4'h1};
      7'h24:   return {1'b1, 4'h2};
      7'h30:   return {1'b1, 4'h3};
      7'h19:   return {1'b1, 4'h4};
      7'h12:   return {1'b1, 4'h5};
      7'h02:   return {1'b1, 4'h6};
      7'h78:   return {1'b1, 4'h7};
      7'h00:   return {1'b1, 4'h8};
      7'h10:   return {1'b1, 4'h9};
      7'h08:   return {1'b1, 4'hA};
      7'h03:   return {1'b1, 4'hB};
      7'h46:   return {1'b1, 4'hC};
      7'h21:   return {1'b1, 4'hD};
      7'h06:   return {1'b1, 4'hE};
      7'h0E:   return {1'b1, 4'hF};
      default: return 5'h00;
    endcase
  endfunction

  always_comb begin
    w_low   = ~r_an_q;
    w_legal = (w_low != '0) &&
              ((w_low & (w_low - 1'b1)) == '0);
    w_match = (r_an_q == r_snap_an) &&
              (r_seg_q == r_snap_seg);
    w_idx   = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_low[i]) w_idx = 4'(i);
    end
    w_dec     = f_decode(r_cap_seg);
    w_set_nxt = r_set | r_cap_sel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_WAIT;
      r_an_q     <= '1;
      r_seg_q    <= 7'h7F;
      r_snap_an  <= '1;
      r_snap_seg <= 7'h7F;
      r_cnt      <= '0;
      r_cap      <= 1'b0;
      r_cap_sel  <= '0;
      r_cap_idx  <= 4'h0;
      r_cap_seg  <= 7'h7F;
    end else begin
      r_an_q  <= an_in;
      r_seg_q <= seg_in;
      r_cap   <= 1'b0;
      if (!w_legal) begin
        r_state <= S_WAIT;
      end else if (r_state == S_SETTLE && w_match) begin
        if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          r_cap     <= 1'b1;
          r_cap_sel <= w_low;
          r_cap_idx <= w_idx;
          r_cap_seg <= r_seg_q;
          r_state   <= S_HOLD;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (r_state != S_HOLD || !w_match) begin
        // new or changed pattern: restart the stability window
        r_snap_an  <= r_an_q;
        r_snap_seg <= r_seg_q;
        r_cnt      <= CNT_W'(1);
        r_state    <= S_SETTLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_digits  <= '0;
      r_valid   <= '0;
      r_set     <= '0;
      r_frame   <= 1'b0;
      r_err     <= 1'b0;
      r_err_idx <= 4'h0;
    end else begin
      r_frame <= 1'b0;
      if (r_cap) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (r_cap_sel[i]) begin
            r_valid[i] <= w_dec[4];
            if (w_dec[4]) r_digits[i] <= w_dec[3:0];
          end
        end
        if (!w_dec[4] && r_cap_seg != 7'h7F) begin
          r_err     <= 1'b1;
          r_err_idx <= r_cap_idx;
        end
        if (&w_set_nxt) begin
          r_frame <= 1'b1;
          r_set   <= '0;
        end else begin
          r_set <= w_set_nxt;
        end
      end
    end
  end

  assign digits_out  = r_digits;
  assign digit_valid = r_valid;
  assign frame_valid = r_frame;
  assign pattern_err = r_err;
  assign err_digit   = r_err_idx;

endmodule
